// File: rtl/intc_pkg.sv
// Shared constants and types for the eight-source interrupt controller.
package intc_pkg;

  localparam int unsigned N_SRC = 8;
  localparam int unsigned IDW   = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } intc_state_t;

  // Edge-history resets high so lines already asserted at reset release are ignored.
  localparam logic [N_SRC-1:0] MASK_RST = 8'hFF;
  localparam logic [N_SRC-1:0] PREV_RST = 8'hFF;

endpackage

// File: rtl/intc_if.sv
// CPU/source-side signal bundle of the interrupt controller.
interface intc_if;

  logic [intc_pkg::N_SRC-1:0] irq_in;
  logic                       mask_we;
  logic [intc_pkg::N_SRC-1:0] mask_wdata;
  logic                       int_ack;
  logic                       eoi;
  logic                       int_req;
  logic [intc_pkg::IDW-1:0]   int_id;
  logic                       in_service;
  logic [intc_pkg::N_SRC-1:0] pending;
  logic [intc_pkg::N_SRC-1:0] mask;

  modport master (
    output irq_in, mask_we, mask_wdata, int_ack, eoi,
    input  int_req, int_id, in_service, pending, mask
  );

  modport slave (
    input  irq_in, mask_we, mask_wdata, int_ack, eoi,
    output int_req, int_id, in_service, pending, mask
  );

endinterface

// File: rtl/prio_enc_v8.sv
// Lowest-set-bit priority encoder over 8 bits; all-zero gives idx=0, valid=0.
module prio_enc_v8
  import intc_pkg::*;
(
  input  logic [N_SRC-1:0] vec,
  output logic [IDW-1:0]   idx,
  output logic             valid
);

  // Scan high to low so the lowest set bit is the last assignment to win.
  always_comb begin
    idx   = '0;
    valid = |vec;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDW'(i);
    end
  end

endmodule

// File: rtl/intc_8src.sv
// Eight-source edge-triggered interrupt controller with fixed priority and
// a request/ack/end-of-interrupt handshake, one interrupt in service at a time.
module intc_8src
  import intc_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  intc_if.slave  bus
);

  logic [N_SRC-1:0] prev_q;
  logic [N_SRC-1:0] pending_q;
  logic [N_SRC-1:0] mask_q;
  logic [N_SRC-1:0] irq_edge;
  logic [N_SRC-1:0] eligible;
  logic [N_SRC-1:0] pending_clr;
  logic [IDW-1:0]   sel;
  logic             valid;
  logic [IDW-1:0]   int_id_q;
  logic             int_req_q;
  logic             in_service_q;
  intc_state_t      state_q;

  assign irq_edge = bus.irq_in & ~prev_q;
  assign eligible = pending_q & ~mask_q;

  prio_enc_v8 u_prio (
    .vec   (eligible),
    .idx   (sel),
    .valid (valid)
  );

  // Acknowledge retires the presented source's pending bit.
  always_comb begin
    pending_clr = '0;
    if (state_q == REQ && bus.int_ack) pending_clr[int_id_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_q       <= PREV_RST;
      pending_q    <= '0;
      mask_q       <= MASK_RST;
      state_q      <= IDLE;
      int_req_q    <= 1'b0;
      int_id_q     <= '0;
      in_service_q <= 1'b0;
    end else begin
      prev_q <= bus.irq_in;
      // A new edge in the clearing cycle keeps the bit set.
      pending_q <= (pending_q & ~pending_clr) | irq_edge;
      if (bus.mask_we) mask_q <= bus.mask_wdata;

      case (state_q)
        IDLE: begin
          if (valid) begin
            state_q   <= REQ;
            int_req_q <= 1'b1;
            int_id_q  <= sel;
          end
        end
        REQ: begin
          if (bus.int_ack) begin
            state_q      <= SERVICE;
            int_req_q    <= 1'b0;
            in_service_q <= 1'b1;
          end else if (!eligible[int_id_q]) begin
            state_q   <= IDLE;
            int_req_q <= 1'b0;
          end
        end
        SERVICE: begin
          if (bus.eoi) begin
            state_q      <= IDLE;
            in_service_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= IDLE;
          int_req_q    <= 1'b0;
          in_service_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.int_req    = int_req_q;
  assign bus.int_id     = int_id_q;
  assign bus.in_service = in_service_q;
  assign bus.pending    = pending_q;
  assign bus.mask       = mask_q;

endmodule

// File: tb/tb_intc_8src.sv
// Directed self-checking bench for intc_8src.
module tb_intc_8src;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  intc_if bus ();

  intc_8src dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input logic [7:0] irq);
    rst_n          = 1'b0;
    bus.irq_in     = irq;
    bus.mask_we    = 1'b0;
    bus.mask_wdata = 8'h00;
    bus.int_ack    = 1'b0;
    bus.eoi        = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic set_mask(input logic [7:0] m);
    bus.mask_we    = 1'b1;
    bus.mask_wdata = m;
    tick();
    bus.mask_we = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(8'h00);
    tests++; if (bus.pending !== 8'h00) begin fails++; $display("FAIL reset_pending: got %h exp 00", bus.pending); end
    tests++; if (bus.mask !== 8'hFF) begin fails++; $display("FAIL reset_mask: got %h exp ff", bus.mask); end
    tests++; if (bus.int_req !== 1'b0) begin fails++; $display("FAIL reset_int_req: got %b exp 0", bus.int_req); end
    tests++; if (bus.int_id !== 3'd0) begin fails++; $display("FAIL reset_int_id: got %0d exp 0", bus.int_id); end
    tests++; if (bus.in_service !== 1'b0) begin fails++; $display("FAIL reset_in_service: got %b exp 0", bus.in_service); end
  endtask

  task automatic test_basic();
    do_reset(8'h00);
    set_mask(8'h00);
    // ack and eoi while idle must be ignored
    bus.int_ack = 1'b1; bus.eoi = 1'b1;
    tick();
    bus.int_ack = 1'b0; bus.eoi = 1'b0;
    tests++; if (bus.in_service !== 1'b0 || bus.int_req !== 1'b0) begin fails++; $display("FAIL basic_idle_ignore: req=%b svc=%b exp 0/0", bus.int_req, bus.in_service); end
    bus.irq_in = 8'h20;
    tick();
    tests++; if (bus.pending !== 8'h20) begin fails++; $display("FAIL basic_pending: got %h exp 20", bus.pending); end
    tests++; if (bus.int_req !== 1'b0) begin fails++; $display("FAIL basic_req_early: got %b exp 0", bus.int_req); end
    tick();
    tests++; if (bus.int_req !== 1'b1 || bus.int_id !== 3'd5) begin fails++; $display("FAIL basic_req: req=%b id=%0d exp 1/5", bus.int_req, bus.int_id); end
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
    tests++; if (bus.int_req !== 1'b0 || bus.in_service !== 1'b1 || bus.pending !== 8'h00) begin fails++; $display("FAIL basic_ack: req=%b svc=%b pend=%h exp 0/1/00", bus.int_req, bus.in_service, bus.pending); end
    bus.eoi = 1'b1;
    tick();
    bus.eoi = 1'b0;
    tests++; if (bus.in_service !== 1'b0 || bus.int_req !== 1'b0) begin fails++; $display("FAIL basic_eoi: svc=%b req=%b exp 0/0", bus.in_service, bus.int_req); end
    bus.irq_in = 8'h00;
  endtask

  task automatic test_priority();
    do_reset(8'h00);
    set_mask(8'h00);
    bus.irq_in = 8'h14;
    tick(2);
    tests++; if (bus.int_req !== 1'b1 || bus.int_id !== 3'd2) begin fails++; $display("FAIL prio_first: req=%b id=%0d exp 1/2", bus.int_req, bus.int_id); end
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
    tests++; if (bus.pending !== 8'h10) begin fails++; $display("FAIL prio_pend_after_ack: got %h exp 10", bus.pending); end
    bus.eoi = 1'b1;
    tick();
    bus.eoi = 1'b0;
    tests++; if (bus.int_req !== 1'b0) begin fails++; $display("FAIL prio_gap: req=%b exp 0", bus.int_req); end
    tick();
    tests++; if (bus.int_req !== 1'b1 || bus.int_id !== 3'd4) begin fails++; $display("FAIL prio_second: req=%b id=%0d exp 1/4", bus.int_req, bus.int_id); end
    bus.irq_in = 8'h00;
  endtask

  task automatic test_no_preempt();
    do_reset(8'h00);
    set_mask(8'h00);
    bus.irq_in = 8'h20;
    tick(2);
    bus.irq_in = 8'h21;
    tick();
    bus.irq_in = 8'h20;
    tests++; if (bus.int_id !== 3'd5 || bus.int_req !== 1'b1 || bus.pending !== 8'h21) begin fails++; $display("FAIL nopre_hold: id=%0d req=%b pend=%h exp 5/1/21", bus.int_id, bus.int_req, bus.pending); end
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
    tests++; if (bus.in_service !== 1'b1 || bus.int_id !== 3'd5 || bus.pending !== 8'h01) begin fails++; $display("FAIL nopre_svc: svc=%b id=%0d pend=%h exp 1/5/01", bus.in_service, bus.int_id, bus.pending); end
    bus.eoi = 1'b1;
    tick();
    bus.eoi = 1'b0;
    tick();
    tests++; if (bus.int_req !== 1'b1 || bus.int_id !== 3'd0) begin fails++; $display("FAIL nopre_next: req=%b id=%0d exp 1/0", bus.int_req, bus.int_id); end
    bus.irq_in = 8'h00;
  endtask

  task automatic test_mask_drop();
    do_reset(8'h00);
    set_mask(8'h00);
    bus.irq_in = 8'h20;
    tick(2);
    set_mask(8'h20);
    tick();
    tests++; if (bus.int_req !== 1'b0 || bus.pending !== 8'h20) begin fails++; $display("FAIL mask_drop: req=%b pend=%h exp 0/20", bus.int_req, bus.pending); end
    set_mask(8'h00);
    tick();
    tests++; if (bus.int_req !== 1'b1 || bus.int_id !== 3'd5) begin fails++; $display("FAIL mask_rereq: req=%b id=%0d exp 1/5", bus.int_req, bus.int_id); end
    bus.irq_in = 8'h00;
  endtask

  task automatic test_set_wins();
    do_reset(8'h00);
    set_mask(8'h00);
    bus.irq_in = 8'h08;
    tick(2);
    bus.irq_in = 8'h00;
    tick();
    tests++; if (bus.int_req !== 1'b1 || bus.int_id !== 3'd3) begin fails++; $display("FAIL setwin_req: req=%b id=%0d exp 1/3", bus.int_req, bus.int_id); end
    bus.irq_in  = 8'h08;
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
    tests++; if (bus.in_service !== 1'b1 || bus.pending !== 8'h08) begin fails++; $display("FAIL setwin_pend: svc=%b pend=%h exp 1/08", bus.in_service, bus.pending); end
    bus.eoi = 1'b1;
    tick();
    bus.eoi = 1'b0;
    tick();
    tests++; if (bus.int_req !== 1'b1 || bus.int_id !== 3'd3) begin fails++; $display("FAIL setwin_rereq: req=%b id=%0d exp 1/3", bus.int_req, bus.int_id); end
    bus.irq_in = 8'h00;
  endtask

  task automatic test_reset_cases();
    do_reset(8'hFF);
    tick(2);
    set_mask(8'h00);
    tick();
    tests++; if (bus.pending !== 8'h00 || bus.int_req !== 1'b0) begin fails++; $display("FAIL rst_high_lines: pend=%h req=%b exp 00/0", bus.pending, bus.int_req); end
    bus.irq_in = 8'h7F;
    tick();
    bus.irq_in = 8'hFF;
    tick(2);
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
    tests++; if (bus.in_service !== 1'b1 || bus.int_id !== 3'd7) begin fails++; $display("FAIL rst_pre_svc: svc=%b id=%0d exp 1/7", bus.in_service, bus.int_id); end
    rst_n = 1'b0;
    tick();
    tests++; if (bus.in_service !== 1'b0 || bus.int_req !== 1'b0 || bus.int_id !== 3'd0) begin fails++; $display("FAIL rst_mid_ctl: svc=%b req=%b id=%0d exp 0/0/0", bus.in_service, bus.int_req, bus.int_id); end
    tests++; if (bus.pending !== 8'h00 || bus.mask !== 8'hFF) begin fails++; $display("FAIL rst_mid_regs: pend=%h mask=%h exp 00/ff", bus.pending, bus.mask); end
    rst_n = 1'b1;
    bus.irq_in = 8'h00;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_no_preempt();
    test_mask_drop();
    test_set_wins();
    test_reset_cases();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/intc_8src.md
# intc_8src

Eight-source interrupt controller for the MiniComputer CPU. It rising-edge-detects eight interrupt lines, latches them as pending, and applies a per-source mask. It selects the lowest-numbered eligible source (fixed priority, bit 0 highest) and runs a request/acknowledge/end-of-interrupt handshake with the CPU, with one interrupt in service at a time.

## Interface
- `N_SRC`, 8: number of interrupt sources; fixed at 8 in this revision.
- `IDW`, 3: width of the interrupt ID, log2(`N_SRC`).

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `irq_in`  in  8  interrupt lines, synchronous to `clk`; a rising edge sets pending.
- `mask_we`  in  1  write strobe for the mask register.
- `mask_wdata`  in  8  new mask value; bit=1 masks that source.
- `int_ack`  in  1  CPU accepts the presented interrupt; meaningful only while `int_req`=1.
- `eoi`  in  1  CPU signals end of service of the in-service interrupt.
- `int_req`  out  1  interrupt request to the CPU.
- `int_id`  out  3  ID of the requested or in-service source.
- `in_service`  out  1  an interrupt is being serviced.
- `pending`  out  8  pending register, readable status.
- `mask`  out  8  mask register, readable status.

## Operation
- Edge detect: `prev` <= `irq_in` every cycle. `edge` = `irq_in` & ~`prev`. `prev` resets to 8'hFF, so lines already high at reset release produce no edge.
- Pending: `pending[i]` is set by `edge[i]` and cleared when source i is acknowledged. If set and clear happen in the same cycle, set wins and the bit stays 1.
- Mask: loaded from `mask_wdata` on `mask_we`. Masked sources keep latching pending but are not eligible.
- `eligible` = `pending` & ~`mask`. `sel` = index of the lowest set bit of `eligible`. `valid` = |`eligible`.
- FSM states: IDLE, REQ, SERVICE.
  - IDLE: if `valid`, go to REQ and latch `int_id` <= `sel`.
  - REQ: `int_req`=1 and `int_id` is held stable; a higher-priority arrival does not preempt.
    - If `int_ack`: clear `pending[int_id]` and go to SERVICE.
    - Else if the selected source is no longer eligible (masked by `mask_we` this cycle): go to IDLE with `int_req` dropped and pending kept.
  - SERVICE: `in_service`=1 and `int_id` is held. On `eoi`, go to IDLE.
- `eoi` outside SERVICE is ignored. `int_ack` outside REQ is ignored.
- Reset values: `pending`=0, `mask`=8'hFF, state=IDLE, `int_req`=0, `int_id`=0, `in_service`=0.
- Reset asserted mid-operation returns everything to reset values on the next edge. An interrupt in service is lost.

## Timing
- All outputs are registered.
- `irq_in` rising at edge k (sampled): `pending` set after edge k. If unmasked, IDLE→REQ at edge k+1, so `int_req`=1 from k+1.
- Edge-to-`int_req` latency: 2 cycles minimum.
- `int_ack` sampled high in REQ at edge m: `int_req`=0, `in_service`=1, and the pending bit cleared after edge m.
- `eoi` at edge n: `in_service`=0 after n. The next `int_req` comes no earlier than edge n+1.
- A mask write takes effect on the eligibility computed in the following cycle.
- Throughput: at most one interrupt per 3 cycles (REQ, SERVICE, IDLE).

## Structure
- Package `intc_pkg` holds:
  - `N_SRC` and `IDW` constants;
  - the `intc_state_t` enum {IDLE, REQ, SERVICE};
  - `MASK_RST` = 8'hFF and `PREV_RST` = 8'hFF.
- Sub-module `prio_enc_v8`: combinational lowest-set-bit encoder over 8 bits with outputs `idx[2:0]` and `valid`. The all-zero input gives `valid`=0 and `idx`=0, with no unbounded search.
- Top level contains the edge detector, the pending and mask registers, and the FSM.

## Test plan
- Reset, then `mask_we` with 8'h00 and `irq_in` 8'h00→8'h20 → `pending`=8'h20 after 1 cycle. `int_req`=1 with `int_id`=5 one cycle later.
- `irq_in`=8'h14 in one cycle, mask 8'h00 → `int_id`=2. After ack and `eoi`, the next request has `int_id`=4.
- In REQ on source 5, pulse `irq_in[0]` → `int_id` stays 5 with no preemption. After `eoi`, `int_id`=0.
- Mask 8'h20 while REQ on source 5 → `int_req` drops next cycle and `pending[5]` stays 1. Unmask with 8'h00 → REQ on source 5 again.
- New edge on source 3 in the same cycle as `int_ack` for source 3 → `pending[3]`=1 after SERVICE. A second request with `int_id`=3 follows `eoi`.
- `irq_in`=8'hFF held through reset release → `pending` stays 0. Assert `rst_n`=0 during SERVICE → all outputs return to reset values after one edge.
